nios2_mem_tester: RTL
=====================

# nios2_mem_tester

Avalon-MM initiator that exercises the single-port 1024×32 on-chip memory from the other side of its slave port. On a command it either fills a block of words with a seeded incrementing pattern or reads that block back and checks it, reporting error count and first failing address. It sits beside the Nios II data master in the lights system and is used for power-on memory self-test and bring-up diagnostics.

## Interface
- ADDR_W, 10, word address width of the target memory
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 11, command length width (covers 0..1024 words)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = FILL, 1 = CHECK
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words (0..1024)
- cmd_seed  in  DATA_W  pattern seed
- busy  out  1  high from acceptance until the done cycle inclusive
- done  out  1  one-cycle completion pulse
- err_count  out  LEN_W  CHECK mismatches in the last command
- first_err_addr  out  ADDR_W  address of the first mismatch; valid when err_count != 0
- address  out  ADDR_W  Avalon address
- byteenable  out  DATA_W/8  always all ones
- chipselect  out  1  access strobe
- write  out  1  write qualifier
- writedata  out  DATA_W  write data
- clken  out  1  memory clock enable, constant 1
- readdata  in  DATA_W  memory read data, valid the cycle after the address is presented

## Operation
- States: IDLE, FILL, CHECK, DRAIN, DONE.
- IDLE: cmd_ready = 1. On accept, latch base, len, seed, op. Clear err_count and first_err_addr, and zero index i. Next state: len == 0 → DONE; op 0 → FILL; op 1 → CHECK.
- FILL: each cycle drive chipselect = 1, write = 1, address = (base + i) mod 2^ADDR_W, writedata = (seed + i) mod 2^DATA_W. After the access with i = len-1, go to DONE.
- CHECK: each cycle drive chipselect = 1, write = 0, with address as in FILL. A one-deep pipeline holds the expected value (seed + i) and the address. On the following cycle, readdata is compared with the expected value. On mismatch, err_count increments, and first_err_addr is loaded if err_count was 0. After the read with i = len-1, go to DRAIN.
- DRAIN: no access. Perform the final compare, then go to DONE.
- DONE: done = 1 for one cycle, busy = 1, then go to IDLE. Status outputs hold until the next accept.
- Address wraps modulo 1024: base 1020 with len 8 touches 1020..1023 and then 0..3.
- cmd_valid outside IDLE is ignored. No queueing.
- Reset mid-operation abandons the command. The next cycle is IDLE with all bus strobes low.
- Reset values: cmd_ready 1, busy 0, done 0, err_count 0, first_err_addr 0, address 0, byteenable all ones, chipselect 0, write 0, writedata 0, clken 1.

## Timing
- All outputs are registered.
- Command accepted at cycle T. The first access is at T+1.
- FILL len N: accesses occur at T+1..T+N; done at T+N+1; cmd_ready at T+N+2.
- CHECK len N: reads at T+1..T+N; compares at T+2..T+N+1; done at T+N+2; cmd_ready at T+N+3.
- len 0: done at T+1 with no access.
- Throughput is one word per cycle. The target has no waitrequest, so none is handled.

## Configuration
- NIOS2_MEM_TESTER_STOP_ON_ERR_EN defined:
  - CHECK aborts at the first mismatch. A mismatch compared in cycle c forces chipselect low from c+1, and the read issued at c is discarded.
  - done pulses at c+1. err_count is then exactly 1.
- Not defined: CHECK always runs all len words and counts every mismatch.

## Test plan
- Reset, then FILL base 0, len 4, seed 0x100 → writes 0x100..0x103 to addresses 0..3 on consecutive cycles T+1..T+4; done at T+5; err_count 0.
- FILL then CHECK base 1020, len 8, seed 0xFFFFFFFE → addresses 1020..1023, 0..3; data wraps 0xFFFFFFFE, 0xFFFFFFFF, 0, 1, …; done at T+10; err_count 0.
- FILL seed 0, then corrupt address 5 via the memory model, then CHECK base 0, len 16, seed 0 → err_count 1, first_err_addr 5. With STOP_ON_ERR_EN, done occurs the cycle after the address-5 compare.
- CHECK len 0 → done at T+1, chipselect never asserted, status cleared.
- Assert reset during FILL at i = 3 of len 10 → the next cycle is IDLE with chipselect 0 and cmd_ready 1, and no further writes occur.
- Pulse cmd_valid while busy → ignored. The original command completes with its own length and seed.

Source files
------------

// File: rtl/nios2_mem_tester.sv
// rtl/nios2_mem_tester.sv - Avalon-MM FILL/CHECK self-test initiator for a 1024x32 on-chip memory (optional NIOS2_MEM_TESTER_STOP_ON_ERR_EN)
module nios2_mem_tester #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_op,
   input  logic [ADDR_W-1:0]   cmd_base,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic [DATA_W-1:0]   cmd_seed,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    err_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t              state, state_next;
   logic [LEN_W-1:0]    idx, idx_next;
   logic [ADDR_W-1:0]   base_q;
   logic [LEN_W-1:0]    len_q;
   logic [DATA_W-1:0]   seed_q;

   // One-deep read pipeline: expected word and its address, compared when readdata arrives
   logic                pv;
   logic [DATA_W-1:0]   exp_q;
   logic [ADDR_W-1:0]   exp_addr_q;

   logic                accept, last, compare, mismatch;
   logic [LEN_W-1:0]    err_next;
   logic [ADDR_W-1:0]   ferr_next;
   logic [ADDR_W-1:0]   base_sel, addr_next;
   logic [DATA_W-1:0]   seed_sel, wdata_next;
   logic                access_next, write_next;

   // The memory has no stalls, so these never change
   assign byteenable = '1;
   assign clken      = 1'b1;

   // Next-state, index, status and next bus values; bus outputs are registered from these
   always_comb begin
      state_next = state;
      idx_next   = idx;
      accept     = 1'b0;
      err_next   = err_count;
      ferr_next  = first_err_addr;
      compare    = pv && ((state == S_CHECK) || (state == S_DRAIN));
      mismatch   = compare && (readdata != exp_q);
      last       = (idx == (len_q - LEN_ONE));

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               idx_next  = '0;
               err_next  = '0;
               ferr_next = '0;
               if (cmd_len == '0)
                  state_next = S_DONE;
               else if (cmd_op)
                  state_next = S_CHECK;
               else
                  state_next = S_FILL;
            end
         end
         S_FILL: begin
            if (last)
               state_next = S_DONE;
            else
               idx_next = idx + LEN_ONE;
         end
         S_CHECK: begin
`ifdef NIOS2_MEM_TESTER_STOP_ON_ERR_EN
            // Abort: the read presented this cycle is dropped, done follows directly
            if (mismatch)
               state_next = S_DONE;
            else if (last)
               state_next = S_DRAIN;
            else
               idx_next = idx + LEN_ONE;
`else
            if (last)
               state_next = S_DRAIN;
            else
               idx_next = idx + LEN_ONE;
`endif
         end
         S_DRAIN: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      if (mismatch) begin
         err_next = err_count + LEN_ONE;
         if (err_count == '0)
            ferr_next = exp_addr_q;
      end

      // On the accept cycle the latched command is not yet visible, use the inputs
      base_sel    = accept ? cmd_base : base_q;
      seed_sel    = accept ? cmd_seed : seed_q;
      access_next = (state_next == S_FILL) || (state_next == S_CHECK);
      write_next  = (state_next == S_FILL);
      addr_next   = access_next ? (base_sel + idx_next[ADDR_W-1:0]) : '0;
      wdata_next  = write_next ? (seed_sel + DATA_W'(idx_next)) : '0;
   end

   // State, command latch, compare pipeline and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         idx            <= '0;
         base_q         <= '0;
         len_q          <= '0;
         seed_q         <= '0;
         pv             <= 1'b0;
         exp_q          <= '0;
         exp_addr_q     <= '0;
         cmd_ready      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         address        <= '0;
         chipselect     <= 1'b0;
         write          <= 1'b0;
         writedata      <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (accept) begin
            base_q <= cmd_base;
            len_q  <= cmd_len;
            seed_q <= cmd_seed;
         end
         pv             <= (state == S_CHECK);
         exp_q          <= seed_q + DATA_W'(idx);
         exp_addr_q     <= base_q + idx[ADDR_W-1:0];
         cmd_ready      <= (state_next == S_IDLE);
         busy           <= (state_next != S_IDLE);
         done           <= (state_next == S_DONE);
         err_count      <= err_next;
         first_err_addr <= ferr_next;
         address        <= addr_next;
         chipselect     <= access_next;
         write          <= write_next;
         writedata      <= wdata_next;
      end
   end

endmodule
